retreo_out_capture: RTL and testbench

- Downstream consumer of the ReTReO core's 16-bit Out_Reg port.
- Watches Out_Reg every clock and pushes each new value into a small FIFO.
- Presents the captured values to the host/debug side through a valid/ready drain interface.
- Raises a stall-request hint before it fills, so the bench or top level can hold the core (for example via Override_Stall gating).

---
 rtl/retreo_out_capture.sv | 131 +++++++++++++
 tb/tb_retreo_out_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/retreo_out_capture.sv
// retreo_out_capture: watches the ReTReO core's Out_Reg port and queues every
// new value in a small show-ahead FIFO. A valid/ready port drains the FIFO.
// stall_req is raised one entry before the FIFO is full so the core can be held.
// Optional build macro RETREO_OUT_TIMESTAMP_EN stores a 16-bit cycle timestamp
// with each entry and presents it on m_time.
module retreo_out_capture #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Out_Reg,
    input  logic             cap_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
`ifdef RETREO_OUT_TIMESTAMP_EN
    output logic [15:0]      m_time,
`endif
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic             stall_req
);

`ifdef RETREO_OUT_TIMESTAMP_EN
    localparam int EW = WIDTH + 16;
`else
    localparam int EW = WIDTH;
`endif

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             overflow_reg;
    logic             prev_valid_reg;
    logic [WIDTH-1:0] prev_reg;
    logic [EW-1:0]    entry_next;
    logic [EW-1:0]    head;

    logic pop;
    logic push_req;
    logic push;
    logic drop;

`ifdef RETREO_OUT_TIMESTAMP_EN
    logic [15:0] ts_reg;

    // Free-running cycle counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + 16'd1;
        end
    end

    assign entry_next = {ts_reg, Out_Reg};
    assign m_time     = head[EW-1:WIDTH];
`else
    assign entry_next = Out_Reg;
`endif

    // Flags decode straight from the registered occupancy.
    assign count     = count_reg;
    assign full      = (count_reg == DEPTH_C);
    assign empty     = (count_reg == '0);
    assign m_valid   = !empty;
    assign stall_req = (count_reg >= (DEPTH_C - (AW+1)'(1)));
    assign overflow  = overflow_reg;

    // Show-ahead head: the entry at rd_ptr is always on the output.
    assign head   = mem[rd_ptr_reg];
    assign m_data = head[WIDTH-1:0];

    // Handshake and change-detect decisions for this edge.
    always_comb begin
        pop      = m_valid && m_ready;
        push_req = cap_en && (!prev_valid_reg || (Out_Reg != prev_reg));
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    // Storage array; contents are not reset, only qualified by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= entry_next;
        end
    end

    // Pointers, occupancy, last-seen value and the sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            prev_valid_reg <= 1'b0;
            prev_reg       <= '0;
        end else begin
            if (cap_en) begin
                prev_reg       <= Out_Reg;
                prev_valid_reg <= 1'b1;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_retreo_out_capture.sv
// Bench for retreo_out_capture: an occupancy/queue reference model fed by the
// stimulus process, and a mid-cycle monitor that checks flags every cycle and
// pops the scoreboard whenever the DUT hands over a head entry.
module tb_retreo_out_capture;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] out_reg = '0;
    logic             cap_en = 1'b0;
    logic             m_ready = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             stall_req;
`ifdef RETREO_OUT_TIMESTAMP_EN
    logic [15:0]      m_time;
`endif

    retreo_out_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Out_Reg   (out_reg),
        .cap_en    (cap_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
`ifdef RETREO_OUT_TIMESTAMP_EN
        .m_time    (m_time),
`endif
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: occupancy and sticky flag now and after next edge.
    int          cur_cnt = 0;
    int          nxt_cnt = 0;
    bit          cur_ovf = 1'b0;
    bit          nxt_ovf = 1'b0;
    bit          prev_v  = 1'b0;
    logic [15:0] prev    = '0;
    int unsigned edge_idx = 0;
    logic [15:0] sb_data [$];
    logic [15:0] sb_time [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Effect of the upcoming edge given the inputs now applied.
    task automatic model_step();
        bit pop_m, preq, acc, drop;
        pop_m = (cur_cnt > 0) && m_ready;
        preq  = cap_en && (!prev_v || (out_reg != prev));
        if (cap_en) begin
            prev   = out_reg;
            prev_v = 1'b1;
        end
        acc  = preq && ((cur_cnt < DEPTH) || pop_m);
        drop = preq && (cur_cnt == DEPTH) && !pop_m;
        nxt_cnt = cur_cnt + int'(acc) - int'(pop_m);
        nxt_ovf = drop ? 1'b1 : (ovf_clr ? 1'b0 : cur_ovf);
        if (acc) begin
            sb_data.push_back(out_reg);
            sb_time.push_back(edge_idx[15:0]);
        end
        edge_idx++;
    endtask

    task automatic drive(input logic [15:0] val, input bit en, input bit rdy, input bit clr);
        @(posedge clk);
        #1;
        cur_cnt = nxt_cnt;
        cur_ovf = nxt_ovf;
        out_reg = val;
        cap_en  = en;
        m_ready = rdy;
        ovf_clr = clr;
        model_step();
        $display("cyc in=0x%04h en=%0d rdy=%0d clr=%0d exp_cnt=%0d", val, en, rdy, clr, nxt_cnt);
    endtask

    task automatic reset_model();
        sb_data.delete();
        sb_time.delete();
        cur_cnt  = 0;
        nxt_cnt  = 0;
        cur_ovf  = 1'b0;
        nxt_ovf  = 1'b0;
        prev_v   = 1'b0;
        prev     = '0;
        edge_idx = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},    32'(count),     32'd0);
        check({tag, "_empty"},    32'(empty),     32'd1);
        check({tag, "_full"},     32'(full),      32'd0);
        check({tag, "_m_valid"},  32'(m_valid),   32'd0);
        check({tag, "_overflow"}, 32'(overflow),  32'd0);
        check({tag, "_stall"},    32'(stall_req), 32'd0);
    endtask

    // Asynchronous reset asserted mid-cycle, then released after two edges.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        $display("async reset asserted at %0t", $time);
        reset_model();
        cap_en  = 1'b0;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_step();
    endtask

    // Monitor: mid-cycle flag checks and scoreboard pops on handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count",     32'(count),     32'(cur_cnt));
            check("full",      32'(full),      32'(cur_cnt == DEPTH));
            check("empty",     32'(empty),     32'(cur_cnt == 0));
            check("stall_req", 32'(stall_req), 32'(cur_cnt >= DEPTH - 1));
            check("m_valid",   32'(m_valid),   32'(cur_cnt > 0));
            check("overflow",  32'(overflow),  32'(cur_ovf));
            if (m_valid && m_ready) begin
                if (sb_data.size() == 0) begin
                    check("pop_unexpected", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    logic [15:0] ed, et;
                    ed = sb_data.pop_front();
                    et = sb_time.pop_front();
                    check("m_data", 32'(m_data), 32'(ed));
`ifdef RETREO_OUT_TIMESTAMP_EN
                    check("m_time", 32'(m_time), 32'(et));
`endif
                    $display("pop data=0x%04h exp=0x%04h time_exp=%0d", m_data, ed, et);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        reset_model();
        model_step();

        // Steady value: one push only, then drain it.
        repeat (10) drive(16'd4, 1'b1, 1'b0, 1'b0);
        repeat (3) drive(16'd4, 1'b1, 1'b1, 1'b0);

        // Ordering.
        for (int i = 1; i <= 3; i++) drive(16'(i), 1'b1, 1'b0, 1'b0);
        repeat (5) drive(16'd3, 1'b1, 1'b1, 1'b0);

        // Fill, overflow drop, clear, drain.
        for (int i = 0; i < 8; i++) drive(16'(16'h10 + i), 1'b1, 1'b0, 1'b0);
        drive(16'h18, 1'b1, 1'b0, 1'b0);
        drive(16'h18, 1'b1, 1'b0, 1'b0);
        drive(16'h18, 1'b0, 1'b0, 1'b1);
        // Drop coinciding with clear keeps the flag set.
        drive(16'h19, 1'b1, 1'b0, 1'b1);
        drive(16'h19, 1'b0, 1'b0, 1'b1);
        repeat (10) drive(16'h19, 1'b0, 1'b1, 1'b0);

        // Full plus simultaneous pop and push.
        for (int i = 0; i < 8; i++) drive(16'(16'h20 + i), 1'b1, 1'b0, 1'b0);
        drive(16'h28, 1'b1, 1'b1, 1'b0);
        repeat (10) drive(16'h28, 1'b0, 1'b1, 1'b0);

        // Reset while full, then the first enabled cycle pushes a zero.
        for (int i = 0; i < 8; i++) drive(16'(16'h30 + i), 1'b1, 1'b0, 1'b0);
        mid_reset();
        drive(16'h0000, 1'b1, 1'b0, 1'b0);
        drive(16'h0000, 1'b1, 1'b1, 1'b0);
        drive(16'h0000, 1'b1, 1'b1, 1'b0);

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) mid_reset();
            drive(16'($urandom_range(0, 5)),
                  ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) < ((n / 300) % 2 == 0 ? 3 : 7)),
                  ($urandom_range(0, 19) == 0));
        end
        repeat (12) drive(16'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
